tsum_avg_divider: RTL and testbench

- Downstream consumer of the 14-sample sliding-window register file.
- Takes the window sum Tsum and the fill count N, and computes the mean temperature AVG = Tsum / N with a bit-serial restoring divider, one quotient bit per clock.
- Produces a one-cycle VALID strobe with the result, for the display/threshold logic further downstream.

---
 rtl/tsum_avg_divider.sv | 155 +++++++++++++++
 tb/tb_tsum_avg_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tsum_avg_divider.sv
// tsum_avg_divider: mean temperature AVG = Tsum / N via a bit-serial
// restoring divider that produces one quotient bit per clock.
// Ports: CLK, RESET (async, active-high), START, Tsum[SUM_W], N[N_W] in;
//        AVG[OUT_W] (saturated, held), VALID (1-cycle strobe), BUSY,
//        OVF (AVG saturated), DIV_ZERO (last request had N == 0) out.
// Option: define TSUM_AVG_ROUND_EN to round to nearest (Tsum + N/2).
module tsum_avg_divider #(
  parameter int SUM_W = 14,
  parameter int N_W   = 4,
  parameter int OUT_W = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [SUM_W-1:0] Tsum,
  input  logic [N_W-1:0]   N,
  output logic [OUT_W-1:0] AVG,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVF,
  output logic             DIV_ZERO
);

`ifdef TSUM_AVG_ROUND_EN
  localparam int DVD_W = SUM_W + 1;
`else
  localparam int DVD_W = SUM_W;
`endif
  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DVD_W-1:0] r_dvd;
  logic [DVD_W-1:0] r_quo;
  logic [N_W-1:0]   r_div;
  logic [N_W:0]     r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zflag;
  logic [OUT_W-1:0] r_avg;
  logic             r_valid;
  logic             r_busy;
  logic             r_ovf;
  logic             r_div_zero;

  logic [DVD_W-1:0] w_dvd_in;
  logic [N_W+1:0]   w_sh;
  logic             w_ge;
  logic [N_W:0]     w_sub;
  logic             w_ovf;

`ifdef TSUM_AVG_ROUND_EN
  // Adding N/2 before dividing turns truncation into round-to-nearest.
  assign w_dvd_in = DVD_W'(Tsum) + DVD_W'(N >> 1);
`else
  assign w_dvd_in = Tsum;
`endif

  // Remainder is always < divisor, so the shifted value fits in N_W+1
  // bits; the extra top bit only keeps the compare full-width.
  assign w_sh  = {r_rem, r_dvd[DVD_W-1]};
  assign w_ge  = w_sh >= {2'b00, r_div};
  assign w_sub = w_sh[N_W:0] - {1'b0, r_div};
  assign w_ovf = |r_quo[DVD_W-1:OUT_W];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next = (N != '0) ? S_DIVIDE : S_DONE;
        end
      end
      S_DIVIDE: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_dvd      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_zflag    <= 1'b0;
      r_avg      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            r_busy <= 1'b1;
            r_rem  <= '0;
            r_quo  <= '0;
            if (N != '0) begin
              r_dvd   <= w_dvd_in;
              r_div   <= N;
              r_cnt   <= CNT_W'(DVD_W);
              r_zflag <= 1'b0;
            end else begin
              r_zflag <= 1'b1;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_ge ? w_sub : w_sh[N_W:0];
          r_quo <= {r_quo[DVD_W-2:0], w_ge};
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          r_valid    <= 1'b1;
          r_busy     <= 1'b0;
          r_div_zero <= r_zflag;
          if (r_zflag) begin
            r_avg <= '0;
            r_ovf <= 1'b0;
          end else if (w_ovf) begin
            r_avg <= '1;
            r_ovf <= 1'b1;
          end else begin
            r_avg <= r_quo[OUT_W-1:0];
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign AVG      = r_avg;
  assign VALID    = r_valid;
  assign BUSY     = r_busy;
  assign OVF      = r_ovf;
  assign DIV_ZERO = r_div_zero;

endmodule

// File: tb/tb_tsum_avg_divider.sv
// Scoreboard bench for tsum_avg_divider: directed vectors push expected
// results; a negedge monitor pops and checks on every VALID strobe.
`timescale 1ns/1ps
module tb_tsum_avg_divider;

`ifdef TSUM_AVG_ROUND_EN
  localparam int  LAT   = 16;
  localparam bit  ROUND = 1'b1;
`else
  localparam int  LAT   = 15;
  localparam bit  ROUND = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [13:0] Tsum = '0;
  logic [3:0]  N = '0;
  logic [11:0] AVG;
  logic        VALID;
  logic        BUSY;
  logic        OVF;
  logic        DIV_ZERO;

  typedef struct {
    logic [11:0] avg;
    logic        ovf;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  tsum_avg_divider dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .Tsum     (Tsum),
    .N        (N),
    .AVG      (AVG),
    .VALID    (VALID),
    .BUSY     (BUSY),
    .OVF      (OVF),
    .DIV_ZERO (DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET && VALID) begin
      if (q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_valid: got VALID=1 at cycle %0d, required none",
                 cyc);
      end else begin
        e = q.pop_front();
        chk("avg", 32'(AVG), 32'(e.avg));
        chk("ovf", 32'(OVF), 32'(e.ovf));
        chk("div_zero", 32'(DIV_ZERO), 32'(e.dz));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push_exp(input int ea, input bit eo, input bit ez,
                          input int at);
    exp_t e;
    e.avg = 12'(ea);
    e.ovf = eo;
    e.dz  = ez;
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic issue(input int ts, input int n, input int ea,
                       input bit eo, input bit ez, input int lat);
    @(negedge CLK);
    Tsum  = 14'(ts);
    N     = 4'(n);
    START = 1'b1;
    push_exp(ea, eo, ez, cyc + 1 + lat);
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0) break;
      @(negedge CLK);
    end
    if (q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout: got %0d pending results, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge CLK);
    chk("rst_avg", 32'(AVG), 0);
    chk("rst_valid", 32'(VALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_ovf", 32'(OVF), 0);
    chk("rst_dz", 32'(DIV_ZERO), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    issue(1400, 14, 100, 1'b0, 1'b0, LAT);
    chk("busy_start", 32'(BUSY), 1);
    wait_done();
    repeat (3) @(negedge CLK);
    chk("avg_hold", 32'(AVG), 100);
    chk("valid_drop", 32'(VALID), 0);

    issue(500, 0, 0, 1'b0, 1'b1, 1);
    wait_done();
    chk("busy_after_dz", 32'(BUSY), 0);

    issue(10000, 1, 4095, 1'b1, 1'b0, LAT);
    wait_done();
    issue(4095, 1, 4095, 1'b0, 1'b0, LAT);
    wait_done();

    issue(20, 3, ROUND ? 7 : 6, 1'b0, 1'b0, LAT);
    wait_done();

    // Second START mid-division, with Tsum/N changed: must be ignored.
    issue(1400, 14, 100, 1'b0, 1'b0, LAT);
    repeat (4) @(negedge CLK);
    Tsum  = '0;
    N     = 4'd5;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done();
    repeat (20) @(negedge CLK);

    // Asynchronous reset in the middle of DIVIDE.
    issue(1000, 9, 0, 1'b0, 1'b0, LAT);
    repeat (5) @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_avg", 32'(AVG), 0);
    chk("mid_rst_valid", 32'(VALID), 0);
    chk("mid_rst_ovf", 32'(OVF), 0);
    chk("mid_rst_dz", 32'(DIV_ZERO), 0);
    q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    issue(300, 7, ROUND ? 43 : 42, 1'b0, 1'b0, LAT);
    wait_done();

    // START held: second division begins the first IDLE cycle after DONE.
    @(negedge CLK);
    Tsum  = 14'd1400;
    N     = 4'd14;
    START = 1'b1;
    k = cyc + 1;
    push_exp(100, 1'b0, 1'b0, k + LAT);
    push_exp(100, 1'b0, 1'b0, k + 2 * LAT + 1);
    repeat (LAT + 2) @(posedge CLK);
    #1 START = 1'b0;
    wait_done();
    repeat (20) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
